axi_node_cfg_seq: RTL and testbench
===================================

# axi_node_cfg_seq

APB-master sequencer that atomically reprograms one address-map rule in the AXI node's APB configuration register block. A requester issues a single rule-update command. The block then runs a fixed series of APB transfers: read-modify-write clear of the rule's valid bit, START_ADDR write, END_ADDR write, and an optional read-modify-write set of the valid bit. Because the rule is disabled before its addresses change, the node never decodes a half-updated range. The block sits between the system control logic and the configuration register block's APB slave port.

## Interface
- APB_ADDR_WIDTH, 12, APB address width (≥10).
- N_REGION_MAX, 4, regions per master port.
- N_MASTER_PORT, 16, master ports; N_REGION_MAX*N_MASTER_PORT ≤ 64; N_MASTER_PORT ≤ 32.

Ports (reset is asynchronous, active-low):
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  command accept; high only in IDLE.
- cmd_region_i  in  $clog2(N_REGION_MAX)  region index.
- cmd_master_i  in  $clog2(N_MASTER_PORT)  master port index.
- cmd_start_i  in  32  rule start address.
- cmd_end_i  in  32  rule end address.
- cmd_enable_i  in  1  valid bit value after the update.
- done_o  out  1  one-cycle pulse; command completed.
- err_o  out  1  one-cycle pulse; command aborted.
- PADDR_o  out  APB_ADDR_WIDTH  APB address.
- PWDATA_o  out  32  APB write data.
- PWRITE_o  out  1  APB direction.
- PSEL_o  out  1  APB select.
- PENABLE_o  out  1  APB enable.
- PRDATA_i  in  32  APB read data.
- PREADY_i  in  1  APB ready.
- PSLVERR_i  in  1  APB slave error.

## Operation
- Command latch: the command is captured on the edge where cmd_valid_i && cmd_ready_o. Fields are held internally; inputs are ignored until the next IDLE.
- Address map (upper PADDR bits are 0):
  - START: {2'b00, idx, 2'b00}, where idx = region*N_MASTER_PORT + master.
  - END: {2'b01, idx, 2'b00}.
  - VALID: {2'b10, region[5:0], 2'b00}. The VALID word holds one bit per master port.
- State sequence: IDLE → RD_VALID → WR_CLR → WR_START → WR_END → (WR_SET if cmd_enable) → DONE → IDLE.
- RD_VALID: APB read of VALID; PRDATA_i[N_MASTER_PORT-1:0] is captured into vword at the completing edge.
- WR_CLR: writes vword with bit[master] cleared.
- WR_START: writes cmd_start.
- WR_END: writes cmd_end.
- WR_SET: writes the cleared vword with bit[master] set.
- PWDATA upper bits above N_MASTER_PORT are 0 for the VALID writes.
- The vword register is updated only by RD_VALID. Other masters' bits are preserved.
- Error path: PSLVERR_i sampled high with PREADY_i in any access phase aborts the command. The remaining transfers are skipped, err_o pulses instead of done_o, and the FSM returns to IDLE.
- done_o and err_o are mutually exclusive.

## Timing
- Each APB transfer has a SETUP cycle (PSEL=1, PENABLE=0) followed by ACCESS cycles (PSEL=1, PENABLE=1) until PREADY_i=1. There are no idle cycles between transfers.
- PADDR, PWRITE and PWDATA are stable from SETUP through the completing ACCESS cycle.
- Latency with PREADY tied high, counting the accept edge as edge 0:
  - first SETUP in cycle 1;
  - 5 transfers (enable=1) occupy cycles 1–10;
  - done_o is high in cycle 11 (the DONE state);
  - cmd_ready_o returns to 1 in cycle 12.
- With enable=0 there are 4 transfers and done_o is high in cycle 9.
- Wait states: each PREADY_i=0 cycle in ACCESS adds one cycle.
- Reset values: PSEL_o=0, PENABLE_o=0, PWRITE_o=0, PADDR_o=0, PWDATA_o=0, done_o=0, err_o=0; state=IDLE, so cmd_ready_o=1.
- Reset mid-operation: PSEL_o and PENABLE_o drop immediately (asynchronous) and no done_o or err_o is produced. The rule may be left cleared; software reissues the command.
- A command presented during DONE is not accepted until IDLE.

## Configuration
- AXI_NODE_CFG_SEQ_RANGE_CHECK_EN
  - Defined: at accept, a command with cmd_end < cmd_start (unsigned) or region ≥ N_REGION_MAX is rejected. No APB transfer is issued, and err_o pulses in cycle 1.
  - Undefined: no check; every accepted command runs the full sequence.

## Structure
- Package axi_node_cfg_pkg holds:
  - bank-select constants BANK_START=2'b00, BANK_END=2'b01, BANK_VALID=2'b10;
  - the FSM state enum;
  - the helper function cfg_idx(region, master).
- One sub-module, axi_node_apb_xfer: a single-transfer APB master engine (start/addr/wdata/write in; done/rdata/err out). The sequencer FSM drives it once per state.

## Test plan
- Reset, then region=1, master=3, start=0x1000_0000, end=0x1000_FFFF, enable=1, PREADY=1, initial VALID[1]=0x0000_0081. Required:
  - read at addr 0x204;
  - writes 0x204←0x81, 0x04C←0x1000_0000, 0x14C←0x1000_FFFF, 0x204←0x89;
  - done_o in cycle 11.
- Same command with enable=0 and VALID word 0x0000_0008 → writes 0x204←0x0, START, END; no WR_SET; done_o in cycle 9.
- PREADY_i low for 3 cycles in the WR_START access → all signals held stable; done_o delayed to cycle 14.
- PSLVERR_i=1 on the WR_END access → no WR_SET transfer; err_o pulses once, done_o stays 0; cmd_ready_o returns to 1.
- HRESETn asserted during WR_END ACCESS → PSEL_o=0 asynchronously and no pulses. After release, a new command completes normally.
- With AXI_NODE_CFG_SEQ_RANGE_CHECK_EN defined, start=0x2000, end=0x1000 → zero APB cycles and err_o in cycle 1.

Source files
------------

// File: rtl/axi_node_cfg_pkg.sv
// Shared definitions for the AXI node configuration sequencer.
//   - Bank-select codes placed in PADDR[9:8] of the configuration register block.
//   - Sequencer FSM state type.
//   - cfg_idx(): flat rule index of (region, master).
//   - vword_mask(): mask covering the per-master bits of a VALID word.
package axi_node_cfg_pkg;

  localparam logic [1:0] BANK_START = 2'b00;
  localparam logic [1:0] BANK_END   = 2'b01;
  localparam logic [1:0] BANK_VALID = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRdValid,
    StWrClr,
    StWrStart,
    StWrEnd,
    StWrSet,
    StDone
  } cfg_state_e;

  function automatic logic [5:0] cfg_idx(input int unsigned region,
                                         input int unsigned master,
                                         input int unsigned n_master);
    return 6'(region * n_master + master);
  endfunction

  function automatic logic [31:0] vword_mask(input int unsigned n_master);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < n_master) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_node_apb_xfer.sv
// Single-transfer APB master engine.
//   start_i            : launch a transfer; SETUP is driven in the following cycle.
//                        May be asserted in the completing cycle of the previous
//                        transfer so back-to-back transfers need no idle cycle.
//   addr_i/wdata_i/write_i : transfer attributes, sampled with start_i.
//   done_o             : combinational, high in the completing ACCESS cycle.
//   err_o              : done_o qualified by PSLVERR.
//   rdata_o            : PRDATA pass-through, valid while done_o is high.
//   paddr_o..penable_o : registered APB request signals.
module axi_node_apb_xfer #(
  parameter int unsigned AddrW = 12
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  input  logic             write_i,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      rdata_o,
  output logic [AddrW-1:0] paddr_o,
  output logic [31:0]      pwdata_o,
  output logic             pwrite_o,
  output logic             psel_o,
  output logic             penable_o,
  input  logic [31:0]      prdata_i,
  input  logic             pready_i,
  input  logic             pslverr_i
);

  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [AddrW-1:0] paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;

  assign done_o  = psel_q & penable_q & pready_i;
  assign err_o   = done_o & pslverr_i;
  assign rdata_o = prdata_i;

  always_comb begin
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    if (start_i) begin
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = write_i;
      paddr_d   = addr_i;
      pwdata_d  = wdata_i;
    end else if (done_o) begin
      psel_d    = 1'b0;
      penable_d = 1'b0;
    end else if (psel_q) begin
      penable_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else begin
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/axi_node_cfg_seq.sv
// APB-master sequencer that atomically reprograms one AXI node address-map rule:
// clear the rule's VALID bit (read-modify-write), write START_ADDR and END_ADDR,
// then optionally set the VALID bit again.
//   HCLK/HRESETn     : clock, asynchronous active-low reset.
//   cmd_*            : rule-update command (valid/ready handshake, ready only in idle).
//   done_o / err_o   : one-cycle completion / abort pulses (mutually exclusive).
//   P*_o / P*_i      : APB master port towards the configuration register block.
// Optional feature macro: AXI_NODE_CFG_SEQ_RANGE_CHECK_EN rejects commands with
// cmd_end_i < cmd_start_i or an out-of-range region at accept time.
module axi_node_cfg_seq
  import axi_node_cfg_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned N_REGION_MAX   = 4,
  parameter int unsigned N_MASTER_PORT  = 16
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [$clog2(N_REGION_MAX)-1:0]  cmd_region_i,
  input  logic [$clog2(N_MASTER_PORT)-1:0] cmd_master_i,
  input  logic [31:0]                      cmd_start_i,
  input  logic [31:0]                      cmd_end_i,
  input  logic                             cmd_enable_i,
  output logic                             done_o,
  output logic                             err_o,
  output logic [APB_ADDR_WIDTH-1:0]        PADDR_o,
  output logic [31:0]                      PWDATA_o,
  output logic                             PWRITE_o,
  output logic                             PSEL_o,
  output logic                             PENABLE_o,
  input  logic [31:0]                      PRDATA_i,
  input  logic                             PREADY_i,
  input  logic                             PSLVERR_i
);

  localparam int unsigned RegionW = $clog2(N_REGION_MAX);
  localparam int unsigned MasterW = $clog2(N_MASTER_PORT);
  localparam logic [31:0] VwordMask = vword_mask(N_MASTER_PORT);

  function automatic logic [APB_ADDR_WIDTH-1:0] mk_addr(input logic [1:0] bank,
                                                        input logic [5:0] sel);
    logic [APB_ADDR_WIDTH-1:0] a;
    a       = '0;
    a[9:0]  = {bank, sel, 2'b00};
    return a;
  endfunction

  cfg_state_e         state_q, state_d;
  logic [RegionW-1:0] region_q, region_d;
  logic [MasterW-1:0] master_q, master_d;
  logic [31:0]        start_q, start_d;
  logic [31:0]        end_q, end_d;
  logic               enable_q, enable_d;
  // Kept 32 bits wide but always masked to the per-master bits.
  logic [31:0]        vword_q, vword_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic                      x_start;
  logic [APB_ADDR_WIDTH-1:0] x_addr;
  logic [31:0]               x_wdata;
  logic                      x_write;
  logic                      x_done;
  logic                      x_err;
  logic [31:0]               x_rdata;

  logic        reject;
  logic [31:0] bit_mask;
  logic [5:0]  rule_idx;

`ifdef AXI_NODE_CFG_SEQ_RANGE_CHECK_EN
  assign reject = (cmd_end_i < cmd_start_i) || (32'(cmd_region_i) >= N_REGION_MAX);
`else
  assign reject = 1'b0;
`endif

  assign bit_mask = 32'd1 << master_q;
  assign rule_idx = cfg_idx(32'(region_q), 32'(master_q), N_MASTER_PORT);

  // Each transfer state launches the next transfer in its completing cycle, so the
  // engine sees back-to-back starts and the bus never idles inside a sequence.
  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    master_d = master_q;
    start_d  = start_q;
    end_d    = end_q;
    enable_d = enable_q;
    vword_d  = vword_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    x_start  = 1'b0;
    x_addr   = '0;
    x_wdata  = '0;
    x_write  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          region_d = cmd_region_i;
          master_d = cmd_master_i;
          start_d  = cmd_start_i;
          end_d    = cmd_end_i;
          enable_d = cmd_enable_i;
          if (reject) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            x_start = 1'b1;
            x_addr  = mk_addr(BANK_VALID, 6'(cmd_region_i));
            state_d = StRdValid;
          end
        end
      end
      StRdValid: begin
        if (x_err) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (x_done) begin
          vword_d = x_rdata & VwordMask;
          x_start = 1'b1;
          x_addr  = mk_addr(BANK_VALID, 6'(region_q));
          x_wdata = x_rdata & VwordMask & ~bit_mask;
          x_write = 1'b1;
          state_d = StWrClr;
        end
      end
      StWrClr: begin
        if (x_err) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (x_done) begin
          x_start = 1'b1;
          x_addr  = mk_addr(BANK_START, rule_idx);
          x_wdata = start_q;
          x_write = 1'b1;
          state_d = StWrStart;
        end
      end
      StWrStart: begin
        if (x_err) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (x_done) begin
          x_start = 1'b1;
          x_addr  = mk_addr(BANK_END, rule_idx);
          x_wdata = end_q;
          x_write = 1'b1;
          state_d = StWrEnd;
        end
      end
      StWrEnd: begin
        if (x_err) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (x_done) begin
          if (enable_q) begin
            x_start = 1'b1;
            x_addr  = mk_addr(BANK_VALID, 6'(region_q));
            x_wdata = (vword_q & ~bit_mask) | bit_mask;
            x_write = 1'b1;
            state_d = StWrSet;
          end else begin
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StWrSet: begin
        if (x_err) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (x_done) begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      region_q <= '0;
      master_q <= '0;
      start_q  <= '0;
      end_q    <= '0;
      enable_q <= 1'b0;
      vword_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      master_q <= master_d;
      start_q  <= start_d;
      end_q    <= end_d;
      enable_q <= enable_d;
      vword_q  <= vword_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready_o = (state_q == StIdle);
  assign done_o      = done_q;
  assign err_o       = err_q;

  axi_node_apb_xfer #(
    .AddrW(APB_ADDR_WIDTH)
  ) u_xfer (
    .clk_i     (HCLK),
    .rst_ni    (HRESETn),
    .start_i   (x_start),
    .addr_i    (x_addr),
    .wdata_i   (x_wdata),
    .write_i   (x_write),
    .done_o    (x_done),
    .err_o     (x_err),
    .rdata_o   (x_rdata),
    .paddr_o   (PADDR_o),
    .pwdata_o  (PWDATA_o),
    .pwrite_o  (PWRITE_o),
    .psel_o    (PSEL_o),
    .penable_o (PENABLE_o),
    .prdata_i  (PRDATA_i),
    .pready_i  (PREADY_i),
    .pslverr_i (PSLVERR_i)
  );

endmodule

// File: tb/tb_axi_node_cfg_seq.sv
// Self-checking bench for axi_node_cfg_seq: an APB slave with a word memory,
// directed scenarios plus randomized commands checked against a transaction-level
// model of the rule-update sequence.
module tb_axi_node_cfg_seq;

  localparam int AW = 12;
  localparam int NR = 4;
  localparam int NM = 16;
  localparam logic [31:0] VMASK = (NM == 32) ? 32'hFFFF_FFFF : ((32'd1 << NM) - 32'd1);

  logic          HCLK;
  logic          HRESETn;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_region_i;
  logic [3:0]    cmd_master_i;
  logic [31:0]   cmd_start_i;
  logic [31:0]   cmd_end_i;
  logic          cmd_enable_i;
  logic          done_o;
  logic          err_o;
  logic [AW-1:0] PADDR_o;
  logic [31:0]   PWDATA_o;
  logic          PWRITE_o;
  logic          PSEL_o;
  logic          PENABLE_o;
  logic [31:0]   PRDATA_i;
  logic          PREADY_i;
  logic          PSLVERR_i;

  axi_node_cfg_seq #(
    .APB_ADDR_WIDTH(AW),
    .N_REGION_MAX  (NR),
    .N_MASTER_PORT (NM)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_region_i(cmd_region_i),
    .cmd_master_i(cmd_master_i),
    .cmd_start_i (cmd_start_i),
    .cmd_end_i   (cmd_end_i),
    .cmd_enable_i(cmd_enable_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .PADDR_o     (PADDR_o),
    .PWDATA_o    (PWDATA_o),
    .PWRITE_o    (PWRITE_o),
    .PSEL_o      (PSEL_o),
    .PENABLE_o   (PENABLE_o),
    .PRDATA_i    (PRDATA_i),
    .PREADY_i    (PREADY_i),
    .PSLVERR_i   (PSLVERR_i)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  logic [31:0] mem [0:1023];
  assign PRDATA_i = mem[PADDR_o[9:0]];

  int n_checks = 0;
  int n_fail   = 0;

  // Slave control and transfer log.
  int          wait_tab [8];
  int          err_at;
  int          xfer_n;
  logic        lg_w [$];
  logic [31:0] lg_a [$];
  logic [31:0] lg_d [$];
  int          last_pulse_cyc;
  int          last_nd;
  int          last_ne;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // APB slave: waits from wait_tab per transfer, PSLVERR on transfer err_at,
  // writes land in mem unless errored; address/data/direction must hold in ACCESS.
  task automatic slave_loop();
    int          wl;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        sw;
    wl = 0;
    sa = '0;
    sd = '0;
    sw = 1'b0;
    forever begin
      @(negedge HCLK);
      PREADY_i  = 1'b0;
      PSLVERR_i = 1'b0;
      if (HRESETn && PSEL_o) begin
        if (!PENABLE_o) begin
          sa = 32'(PADDR_o);
          sd = PWDATA_o;
          sw = PWRITE_o;
          wl = wait_tab[xfer_n & 7];
        end else begin
          check_eq("paddr_stable", 32'(PADDR_o), sa);
          check_eq("pwdata_stable", PWDATA_o, sd);
          check_eq("pwrite_stable", 32'(PWRITE_o), 32'(sw));
          if (wl > 0) begin
            wl--;
          end else begin
            PREADY_i  = 1'b1;
            PSLVERR_i = (xfer_n == err_at);
            lg_w.push_back(sw);
            lg_a.push_back(sa);
            lg_d.push_back(sd);
            if (sw && !PSLVERR_i) mem[sa[9:0]] = sd;
            xfer_n++;
          end
        end
      end
    end
  endtask

  task automatic issue(input int r, input int m, input logic [31:0] s, input logic [31:0] e,
                       input logic en, output int acc);
    lg_w.delete();
    lg_a.delete();
    lg_d.delete();
    xfer_n = 0;
    @(negedge HCLK);
    check_eq("ready_before_cmd", 32'(cmd_ready_o), 32'd1);
    cmd_valid_i  = 1'b1;
    cmd_region_i = 2'(r);
    cmd_master_i = 4'(m);
    cmd_start_i  = s;
    cmd_end_i    = e;
    cmd_enable_i = en;
    @(posedge HCLK);
    #1;
    acc = cyc;
    cmd_valid_i  = 1'b0;
    cmd_region_i = 2'($urandom);
    cmd_master_i = 4'($urandom);
    cmd_start_i  = $urandom;
    cmd_end_i    = $urandom;
    cmd_enable_i = 1'($urandom);
  endtask

  task automatic run_cmd(input int r, input int m, input logic [31:0] s, input logic [31:0] e,
                         input logic en);
    int          vaddr, idx, ntx, t, acc, nd, ne, pc;
    logic        rej, experr, finished;
    logic [31:0] v, bitm, clr, vfinal;
    logic        e_w [5];
    logic [31:0] e_a [5];
    logic [31:0] e_d [5];

    // Transaction-level model of the update sequence.
    vaddr = 'h200 + r * 4;
    idx   = r * NM + m;
    v     = mem[vaddr] & VMASK;
    bitm  = 32'd1 << m;
    clr   = v & ~bitm;
    e_w[0] = 1'b0; e_a[0] = 32'(vaddr);             e_d[0] = '0;
    e_w[1] = 1'b1; e_a[1] = 32'(vaddr);             e_d[1] = clr;
    e_w[2] = 1'b1; e_a[2] = 32'(idx * 4);           e_d[2] = s;
    e_w[3] = 1'b1; e_a[3] = 32'('h100 + idx * 4);   e_d[3] = e;
    e_w[4] = 1'b1; e_a[4] = 32'(vaddr);             e_d[4] = clr | bitm;
`ifdef AXI_NODE_CFG_SEQ_RANGE_CHECK_EN
    rej = (e < s);
`else
    rej = 1'b0;
`endif
    experr = rej;
    ntx    = rej ? 0 : (en ? 5 : 4);
    if (!rej && err_at >= 0 && err_at < ntx) begin
      ntx    = err_at + 1;
      experr = 1'b1;
    end
    t = 0;
    for (int i = 0; i < ntx; i++) t += 2 + wait_tab[i];
    vfinal = mem[vaddr];
    for (int i = 1; i < ntx; i++) begin
      if (e_a[i] == 32'(vaddr) && !(experr && i == ntx - 1)) vfinal = e_d[i];
    end

    issue(r, m, s, e, en, acc);
    nd = 0;
    ne = 0;
    pc = -1;
    finished = 1'b0;
    for (int k = 0; k < 300 && !finished; k++) begin
      @(negedge HCLK);
      if (done_o) begin nd++; pc = cyc - acc + 1; end
      if (err_o) begin ne++; pc = cyc - acc + 1; end
      if ((nd + ne) > 0 && cmd_ready_o) finished = 1'b1;
    end
    check_eq("cmd_finished", 32'(finished), 32'd1);
    check_eq("done_pulses", 32'(nd), experr ? 32'd0 : 32'd1);
    check_eq("err_pulses", 32'(ne), experr ? 32'd1 : 32'd0);
    check_eq("pulse_cycle", 32'(pc), 32'(t + 1));
    check_eq("xfer_count", 32'(lg_a.size()), 32'(ntx));
    for (int i = 0; i < ntx && i < lg_a.size(); i++) begin
      check_eq($sformatf("xfer%0d_write", i), 32'(lg_w[i]), 32'(e_w[i]));
      check_eq($sformatf("xfer%0d_addr", i), lg_a[i], e_a[i]);
      if (e_w[i]) check_eq($sformatf("xfer%0d_wdata", i), lg_d[i], e_d[i]);
    end
    check_eq("valid_word_after", mem[vaddr], vfinal);
    last_pulse_cyc = pc;
    last_nd = nd;
    last_ne = ne;
  endtask

  task automatic clear_knobs();
    for (int i = 0; i < 8; i++) wait_tab[i] = 0;
    err_at = -1;
  endtask

  initial begin
    int          acc, r, m, bad;
    logic        found;
    logic [31:0] s, e;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    clear_knobs();
    xfer_n       = 0;
    PREADY_i     = 1'b0;
    PSLVERR_i    = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_region_i = '0;
    cmd_master_i = '0;
    cmd_start_i  = '0;
    cmd_end_i    = '0;
    cmd_enable_i = 1'b0;
    HRESETn      = 1'b0;
    fork
      slave_loop();
    join_none

    // Reset state.
    repeat (2) @(negedge HCLK);
    check_eq("rst_psel", 32'(PSEL_o), 32'd0);
    check_eq("rst_penable", 32'(PENABLE_o), 32'd0);
    check_eq("rst_pwrite", 32'(PWRITE_o), 32'd0);
    check_eq("rst_paddr", 32'(PADDR_o), 32'd0);
    check_eq("rst_pwdata", PWDATA_o, 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_err", 32'(err_o), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready_o), 32'd1);
    HRESETn = 1'b1;

    // Full update with enable.
    mem['h204] = 32'h0000_0081;
    run_cmd(1, 3, 32'h1000_0000, 32'h1000_FFFF, 1'b1);
    check_eq("t1_read_addr", lg_a[0], 32'h204);
    check_eq("t1_clr_data", lg_d[1], 32'h81);
    check_eq("t1_start_addr", lg_a[2], 32'h04C);
    check_eq("t1_end_addr", lg_a[3], 32'h14C);
    check_eq("t1_set_data", lg_d[4], 32'h89);
    check_eq("t1_done_cycle", 32'(last_pulse_cyc), 32'd11);

    // Update leaving the rule disabled.
    mem['h204] = 32'h0000_0008;
    run_cmd(1, 3, 32'h1000_0000, 32'h1000_FFFF, 1'b0);
    check_eq("t2_clr_data", lg_d[1], 32'h0);
    check_eq("t2_xfers", 32'(lg_a.size()), 32'd4);
    check_eq("t2_done_cycle", 32'(last_pulse_cyc), 32'd9);

    // Wait states on WR_START.
    mem['h204] = 32'h0000_0081;
    wait_tab[2] = 3;
    run_cmd(1, 3, 32'h1000_0000, 32'h1000_FFFF, 1'b1);
    check_eq("t3_done_cycle", 32'(last_pulse_cyc), 32'd14);
    clear_knobs();

    // Slave error on WR_END.
    err_at = 3;
    run_cmd(1, 3, 32'h1000_0000, 32'h1000_FFFF, 1'b1);
    check_eq("t4_err_once", 32'(last_ne), 32'd1);
    check_eq("t4_no_done", 32'(last_nd), 32'd0);
    clear_knobs();

    // Reset during WR_END access.
    mem['h204] = 32'h0000_0081;
    issue(1, 3, 32'h1000_0000, 32'h1000_FFFF, 1'b1, acc);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge HCLK);
      if (PSEL_o && PENABLE_o && PADDR_o == 12'h14C) found = 1'b1;
    end
    check_eq("t5_reached_wr_end", 32'(found), 32'd1);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("t5_psel_async", 32'(PSEL_o), 32'd0);
    check_eq("t5_penable_async", 32'(PENABLE_o), 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge HCLK);
      if (done_o || err_o) bad++;
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) begin
      @(negedge HCLK);
      if (done_o || err_o) bad++;
    end
    check_eq("t5_no_pulses", 32'(bad), 32'd0);
    run_cmd(2, 5, 32'h2000_0000, 32'h2000_0FFF, 1'b1);

`ifdef AXI_NODE_CFG_SEQ_RANGE_CHECK_EN
    run_cmd(0, 1, 32'h0000_2000, 32'h0000_1000, 1'b1);
    check_eq("t6_reject_cycle", 32'(last_pulse_cyc), 32'd1);
    check_eq("t6_no_apb", 32'(lg_a.size()), 32'd0);
`endif

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, NR - 1);
      m = $urandom_range(0, NM - 1);
      if ($urandom_range(0, 2) == 0) mem['h200 + r * 4] = $urandom;
      s = $urandom;
      e = ($urandom_range(0, 3) == 0) ? $urandom : s + $urandom_range(0, 'hFFFF);
      for (int i = 0; i < 8; i++)
        wait_tab[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      err_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 4) : -1;
      run_cmd(r, m, s, e, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
